// File: rtl/moore1_defs_pkg.sv
// Shared codes for the 4-state Moore sequencer and its receive-side decoder.
// Holds the state codes, decoded command codes and the decoder FSM encoding.
package moore1_defs;

    localparam logic [1:0] E0 = 2'd0;
    localparam logic [1:0] E1 = 2'd1;
    localparam logic [1:0] E2 = 2'd2;
    localparam logic [1:0] E3 = 2'd3;

    localparam logic [1:0] CMD_A = 2'b10;
    localparam logic [1:0] CMD_B = 2'b01;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        ERR    = 2'd2
    } dec_state_e;

endpackage

// File: rtl/moore1_cmd_fifo.sv
// Small 2-bit command FIFO; a push into a full FIFO only lands when a pop
// happens in the same cycle, otherwise it is dropped.
module moore1_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [1:0] din_i,
    output logic [1:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

endmodule

// File: rtl/moore1_cmd_decoder.sv
// Rebuilds {inA,inB} commands from the observed Moore state code and queues them.
// Define MOORE1_DEC_ERRCNT_EN to build the saturating illegal-jump counter.
module moore1_cmd_decoder
    import moore1_defs::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RESYNC_CYC = 3,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 st_a,
    input  logic                 st_b,
    input  logic                 cmd_ready,
    output logic                 cmd_valid,
    output logic                 cmd_a,
    output logic                 cmd_b,
    output logic                 synced,
    output logic                 err,
    output logic                 ovf,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int SCW = $clog2(RESYNC_CYC + 1);

    dec_state_e     state_q;
    logic [1:0]     prev_q;
    logic [SCW-1:0] stab_q;
    logic           synced_q;
    logic           err_q;
    logic           ovf_q;

    logic [1:0] code;
    logic [1:0] dcmd;
    logic       legal;
    logic       changed;
    logic       push;
    logic       illegal;
    logic       pop;
    logic       full;
    logic       empty;
    logic [1:0] dout;

    assign code    = {st_a, st_b};
    assign changed = (code != prev_q);
    assign push    = (state_q == TRACK) && changed && legal;
    assign illegal = (state_q == TRACK) && changed && !legal;

    always_comb begin
        legal = 1'b0;
        dcmd  = 2'b00;
        case ({prev_q, code})
            {E0, E3}, {E1, E2}, {E2, E1}, {E3, E0}: begin
                legal = 1'b1;
                dcmd  = CMD_B;
            end
            {E0, E1}, {E1, E0}, {E2, E3}, {E3, E2}: begin
                legal = 1'b1;
                dcmd  = CMD_A;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= UNSYNC;
            prev_q   <= E0;
            stab_q   <= '0;
            synced_q <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (push && full && !pop) ovf_q <= 1'b1;
            case (state_q)
                UNSYNC: begin
                    prev_q   <= code;
                    state_q  <= TRACK;
                    synced_q <= 1'b1;
                end
                TRACK: begin
                    if (changed) prev_q <= code;
                    if (illegal) begin
                        err_q    <= 1'b1;
                        state_q  <= ERR;
                        synced_q <= 1'b0;
                        stab_q   <= '0;
                    end
                end
                ERR: begin
                    if (changed) begin
                        prev_q <= code;
                        stab_q <= '0;
                    end else if (stab_q == SCW'(RESYNC_CYC - 1)) begin
                        stab_q   <= '0;
                        state_q  <= TRACK;
                        synced_q <= 1'b1;
                    end else begin
                        stab_q <= stab_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= UNSYNC;
                    synced_q <= 1'b0;
                end
            endcase
        end
    end

    moore1_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (dcmd),
        .dout_o (dout),
        .full_o (full),
        .empty_o(empty)
    );

    assign cmd_valid = !empty;
    assign pop       = cmd_valid && cmd_ready;
    // Mask the head so stale storage never leaks out while empty.
    assign cmd_a     = cmd_valid & dout[1];
    assign cmd_b     = cmd_valid & dout[0];
    assign synced    = synced_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

`ifdef MOORE1_DEC_ERRCNT_EN
    logic [ERR_CNT_W-1:0] errcnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errcnt_q <= '0;
        end else if (illegal && (errcnt_q != '1)) begin
            errcnt_q <= errcnt_q + 1'b1;
        end
    end

    assign err_count = errcnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_moore1_cmd_decoder.sv
// Self-checking bench for moore1_cmd_decoder: vector table plus scoreboarded
// multi-cycle sequences (overflow, full push/pop, reset, resync, err_count).
module tb_moore1_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_ready;
    logic [1:0] code;
    logic       cmd_valid;
    logic       cmd_a;
    logic       cmd_b;
    logic       synced;
    logic       err;
    logic       ovf;
    logic [1:0] err_count;

    int total = 0;
    int bad   = 0;
    logic [1:0] q [$];
    logic [1:0] cur;

    typedef struct {
        logic [1:0] code;
        logic       push;
        logic [1:0] cmd;
    } vec_t;

    vec_t tv [10];

    moore1_cmd_decoder #(
        .FIFO_DEPTH(4),
        .RESYNC_CYC(3),
        .ERR_CNT_W (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .st_a     (code[1]),
        .st_b     (code[0]),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .synced   (synced),
        .err      (err),
        .ovf      (ovf),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (q.size() == 0) begin
                chk("pop_unexpected", int'({cmd_a, cmd_b}), -1);
            end else begin
                chk("pop_cmd", int'({cmd_a, cmd_b}), int'(q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] c, input logic ex,
                        input logic [1:0] cmd);
        code = c;
        cur  = c;
        if (ex) q.push_back(cmd);
        tick();
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 12 && q.size() != 0; i++) tick();
        repeat (2) tick();
        chk(nm, q.size(), 0);
        chk({nm, "_valid"}, int'(cmd_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int exp_cnt;
        logic [1:0] nxt;

        reset     = 1'b1;
        code      = 2'd0;
        cur       = 2'd0;
        cmd_ready = 1'b1;

        tv[0] = '{2'd3, 1'b1, 2'b01};
        tv[1] = '{2'd2, 1'b1, 2'b10};
        tv[2] = '{2'd1, 1'b1, 2'b01};
        tv[3] = '{2'd0, 1'b1, 2'b10};
        tv[4] = '{2'd1, 1'b1, 2'b10};
        tv[5] = '{2'd2, 1'b1, 2'b01};
        tv[6] = '{2'd3, 1'b1, 2'b10};
        tv[7] = '{2'd0, 1'b1, 2'b01};
        tv[8] = '{2'd0, 1'b0, 2'b00};
        tv[9] = '{2'd1, 1'b1, 2'b10};

        #12;
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_cmd", int'({cmd_a, cmd_b}), 0);
        chk("rst_synced", int'(synced), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_errcnt", int'(err_count), 0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("t1_synced0", int'(synced), 1);
        chk("t1_nopush", int'(cmd_valid), 0);

        // T1 and the full legal decode table
        for (int i = 0; i < 10; i++) begin
            step(tv[i].code, tv[i].push, tv[i].cmd);
            chk("vec_err", int'(err), 0);
            chk("vec_synced", int'(synced), 1);
            if (tv[i].push) chk("vec_valid", int'(cmd_valid), 1);
        end
        drain("t1_drain");

        // T2: illegal 1->3, resync after 3 stable cycles
        step(2'd3, 1'b0, 2'b00);
        chk("t2_err", int'(err), 1);
        chk("t2_synced", int'(synced), 0);
        chk("t2_nopush", int'(cmd_valid), 0);
        tick();
        chk("t2_err_pulse", int'(err), 0);
        chk("t2_hold1", int'(synced), 0);
        tick();
        chk("t2_hold2", int'(synced), 0);
        tick();
        chk("t2_resync", int'(synced), 1);
        step(2'd0, 1'b1, 2'b01);
        chk("t2_valid", int'(cmd_valid), 1);
        drain("t2_drain");

        // T3: overflow with cmd_ready low
        cmd_ready = 1'b0;
        step(2'd1, 1'b1, 2'b10);
        step(2'd2, 1'b1, 2'b01);
        step(2'd3, 1'b1, 2'b10);
        step(2'd0, 1'b1, 2'b01);
        chk("t3_no_ovf_yet", int'(ovf), 0);
        step(2'd1, 1'b0, 2'b00);
        chk("t3_ovf", int'(ovf), 1);
        chk("t3_head", int'({cmd_a, cmd_b}), 2);
        tick();
        chk("t3_head_stable", int'({cmd_a, cmd_b}), 2);
        cmd_ready = 1'b1;
        drain("t3_drain");
        chk("t3_ovf_sticky", int'(ovf), 1);

        // T5: reset while 3 entries queued and FSM in ERR
        cmd_ready = 1'b0;
        step(2'd2, 1'b0, 2'b00);
        step(2'd3, 1'b0, 2'b00);
        step(2'd0, 1'b0, 2'b00);
        chk("t5_queued", int'(cmd_valid), 1);
        step(2'd2, 1'b0, 2'b00);
        chk("t5_err", int'(err), 1);
        #3;
        reset = 1'b1;
        #2;
        chk("t5_async_valid", int'(cmd_valid), 0);
        chk("t5_async_synced", int'(synced), 0);
        chk("t5_async_ovf", int'(ovf), 0);
        chk("t5_async_err", int'(err), 0);
        @(posedge clk);
        #1;
        code      = 2'd3;
        cur       = 2'd3;
        reset     = 1'b0;
        cmd_ready = 1'b1;
        tick();
        chk("t5_synced", int'(synced), 1);
        chk("t5_baseline", int'(cmd_valid), 0);
        tick();
        chk("t5_baseline2", int'(cmd_valid), 0);
        step(2'd0, 1'b1, 2'b01);
        chk("t5_valid", int'(cmd_valid), 1);
        drain("t5_drain");

        // T4: full FIFO, push and pop in the same cycle
        cmd_ready = 1'b0;
        step(2'd1, 1'b1, 2'b10);
        step(2'd2, 1'b1, 2'b01);
        step(2'd3, 1'b1, 2'b10);
        step(2'd0, 1'b1, 2'b01);
        cmd_ready = 1'b1;
        step(2'd1, 1'b1, 2'b10);
        cmd_ready = 1'b0;
        chk("t4_ovf", int'(ovf), 0);
        chk("t4_head", int'({cmd_a, cmd_b}), 1);
        step(2'd2, 1'b0, 2'b00);
        chk("t4_still_full", int'(ovf), 1);
        cmd_ready = 1'b1;
        drain("t4_drain");

        // T6: five illegal jumps, err_count saturation
        for (int i = 0; i < 5; i++) begin
            nxt = cur ^ 2'b10;
            step(nxt, 1'b0, 2'b00);
            chk("t6_err", int'(err), 1);
`ifdef MOORE1_DEC_ERRCNT_EN
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
`else
            exp_cnt = 0;
`endif
            chk("t6_errcnt", int'(err_count), exp_cnt);
            repeat (3) tick();
            chk("t6_resync", int'(synced), 1);
        end
        chk("t6_nopush", int'(cmd_valid), 0);
        chk("t6_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
